// File: rtl/iso_hs_rr_arbiter_pkg.sv
// Shared constants and helpers for the isochronous handshake round-robin arbiter.
package iso_hs_arb_pkg;

    localparam int DefaultNumReq    = 4;
    localparam int DefaultDataWidth = 32;

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    typedef logic [idx_width(DefaultNumReq)-1:0] idx_t;

endpackage

// File: rtl/iso_hs_rr_arbiter_pick.sv
// Rotating priority encoder: first set bit of i_valid at or above i_ptr, wrapping to 0.
module iso_hs_rr_pick #(
    parameter int NumReq   = 4,
    parameter int IdxWidth = 2
) (
    input  logic [NumReq-1:0]   i_valid,
    input  logic [IdxWidth-1:0] i_ptr,
    output logic                o_any,
    output logic [IdxWidth-1:0] o_idx
);

    logic [IdxWidth-1:0] w_cand [NumReq];

    // w_cand[k] is the requester at priority rank k; i_ptr is always below NumReq.
    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_cand
            assign w_cand[gi] = (int'(i_ptr) + gi >= NumReq)
                              ? IdxWidth'(int'(i_ptr) + gi - NumReq)
                              : IdxWidth'(int'(i_ptr) + gi);
        end
    endgenerate

    assign o_any = |i_valid;

    always_comb begin
        o_idx = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (i_valid[w_cand[k]]) begin
                o_idx = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/iso_hs_rr_arbiter.sv
// Round-robin arbiter feeding one isochronous 4-phase handshake channel source port.
// Optional one-entry output register: define ISO_HS_ARB_OUT_REG_EN.
module iso_hs_rr_arbiter
    import iso_hs_arb_pkg::*;
#(
    parameter int   NumReq    = DefaultNumReq,
    parameter int   DataWidth = DefaultDataWidth,
    localparam int  IdxWidth  = idx_width(NumReq)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DataWidth-1:0]        out_data_o,
    output logic [IdxWidth-1:0]         out_idx_o
);

    logic [IdxWidth-1:0] r_rr_ptr;
    logic                w_pick_any;
    logic [IdxWidth-1:0] w_pick_idx;

    iso_hs_rr_pick #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .i_valid (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_any   (w_pick_any),
        .o_idx   (w_pick_idx)
    );

`ifdef ISO_HS_ARB_OUT_REG_EN

    logic                 r_full;
    logic [DataWidth-1:0] r_data;
    logic [IdxWidth-1:0]  r_idx;
    logic [IdxWidth-1:0]  w_ptr_next;

    assign w_ptr_next = (w_pick_idx == IdxWidth'(NumReq - 1)) ? '0 : w_pick_idx + IdxWidth'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_full   <= 1'b0;
            r_data   <= '0;
            r_idx    <= '0;
            r_rr_ptr <= '0;
        end else if (r_full) begin
            if (out_ready_i) begin
                r_full <= 1'b0;
            end
        end else if (w_pick_any) begin
            r_full   <= 1'b1;
            r_data   <= req_data_i[int'(w_pick_idx)*DataWidth +: DataWidth];
            r_idx    <= w_pick_idx;
            r_rr_ptr <= w_ptr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
            assign req_ready_o[gi] = rst_ni & ~r_full & w_pick_any
                                   & (w_pick_idx == IdxWidth'(gi));
        end
    endgenerate

    assign out_valid_o = r_full;
    assign out_data_o  = r_data;
    assign out_idx_o   = r_idx;

`else

    logic                r_lock;
    logic [IdxWidth-1:0] r_lock_idx;
    logic [IdxWidth-1:0] w_grant;
    logic [IdxWidth-1:0] w_ptr_next;
    logic                w_out_valid;
    logic                w_fire;

    // Outputs are forced to their idle values while reset is asserted.
    assign w_grant     = !rst_ni ? '0 : (r_lock ? r_lock_idx : w_pick_idx);
    assign w_out_valid = rst_ni & (r_lock | w_pick_any);
    assign w_fire      = w_out_valid & out_ready_i;
    assign w_ptr_next  = (w_grant == IdxWidth'(NumReq - 1)) ? '0 : w_grant + IdxWidth'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_fire) begin
            r_rr_ptr <= w_ptr_next;
            r_lock   <= 1'b0;
        end else if (w_out_valid) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant;
        end
    end

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
            assign req_ready_o[gi] = w_fire & (w_grant == IdxWidth'(gi));
        end
    endgenerate

    assign out_valid_o = w_out_valid;
    assign out_data_o  = req_data_i[int'(w_grant)*DataWidth +: DataWidth];
    assign out_idx_o   = w_grant;

`ifndef SYNTHESIS
    // A locked requester must keep valid high until its handshake completes.
    a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_lock |-> req_valid_i[r_lock_idx]);
`endif

`endif

endmodule

// File: tb/tb_iso_hs_rr_arbiter.sv
// Scoreboard bench for iso_hs_rr_arbiter: a 4-requester and a 3-requester instance.
module tb_iso_hs_rr_arbiter;
    import iso_hs_arb_pkg::*;

    localparam int NA  = 4;
    localparam int DWA = 32;
    localparam int NB  = 3;
    localparam int DWB = 8;

    typedef struct packed {
        idx_t        idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [NA-1:0]     a_valid, a_ready;
    logic [NA*DWA-1:0] a_data;
    logic              a_ovalid, a_oready;
    logic [DWA-1:0]    a_odata;
    logic [1:0]        a_oidx;

    logic [NB-1:0]     b_valid, b_ready;
    logic [NB*DWB-1:0] b_data;
    logic              b_ovalid, b_oready;
    logic [DWB-1:0]    b_odata;
    logic [1:0]        b_oidx;

    exp_t qa[$];
    exp_t qb[$];
    int   errors = 0;
    int   checks = 0;

    iso_hs_rr_arbiter #(.NumReq(NA), .DataWidth(DWA)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_valid), .req_ready_o(a_ready), .req_data_i(a_data),
        .out_valid_o(a_ovalid), .out_ready_i(a_oready),
        .out_data_o(a_odata), .out_idx_o(a_oidx)
    );

    iso_hs_rr_arbiter #(.NumReq(NB), .DataWidth(DWB)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_data_i(b_data),
        .out_valid_o(b_ovalid), .out_ready_i(b_oready),
        .out_data_o(b_odata), .out_idx_o(b_oidx)
    );

    function automatic logic [31:0] da(input int i, input int tag);
        return 32'(((i + 1) << 28) | tag);
    endfunction

    function automatic logic [7:0] db(input int i, input int tag);
        return 8'(((i + 1) << 4) | (tag & 15));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data(input int tag);
        for (int i = 0; i < NA; i++) a_data[i*DWA +: DWA] = da(i, tag);
        for (int i = 0; i < NB; i++) b_data[i*DWB +: DWB] = db(i, tag);
    endtask

    task automatic push_a(input int idx, input int tag);
        qa.push_back('{idx: idx_t'(idx), data: da(idx, tag)});
    endtask

    task automatic push_b(input int idx, input int tag);
        qb.push_back('{idx: idx_t'(idx), data: 32'(db(idx, tag))});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: compare the queue head on every valid cycle, pop on handshake.
    always @(negedge clk) begin
        if (rst_n && a_ovalid) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got idx %0d expected no output", a_oidx);
            end else begin
                logic [NA-1:0] exp_rdy;
`ifdef ISO_HS_ARB_OUT_REG_EN
                exp_rdy = '0;
`else
                exp_rdy = a_oready ? (NA'(1) << qa[0].idx) : '0;
`endif
                check("a_idx", 64'(a_oidx), 64'(qa[0].idx));
                check("a_data", 64'(a_odata), 64'(qa[0].data));
                check("a_req_ready", 64'(a_ready), 64'(exp_rdy));
                if (a_oready) begin
                    $display("A xfer idx=%0d data=%h", a_oidx, a_odata);
                    void'(qa.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_ovalid) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got idx %0d expected no output", b_oidx);
            end else begin
                logic [NB-1:0] exp_rdy;
`ifdef ISO_HS_ARB_OUT_REG_EN
                exp_rdy = '0;
`else
                exp_rdy = b_oready ? (NB'(1) << qb[0].idx) : '0;
`endif
                check("b_idx", 64'(b_oidx), 64'(qb[0].idx));
                check("b_data", 64'(b_odata), 64'(qb[0].data[7:0]));
                check("b_req_ready", 64'(b_ready), 64'(exp_rdy));
                if (b_oready) begin
                    $display("B xfer idx=%0d data=%h", b_oidx, b_odata);
                    void'(qb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        a_valid  = '0;
        a_oready = 1'b0;
        b_valid  = '0;
        b_oready = 1'b0;
        set_data(1);

        // Reset with requests pending: outputs must stay idle.
        a_valid = 4'b1111;
        #2;
        check("rst_valid", 64'(a_ovalid), 64'd0);
        check("rst_ready", 64'(a_ready), 64'd0);
        check("rst_idx", 64'(a_oidx), 64'd0);
`ifndef ISO_HS_ARB_OUT_REG_EN
        check("rst_data", 64'(a_odata), 64'(da(0, 1)));
`endif
        tick();
        tick();
        rst_n   = 1'b1;
        a_valid = '0;
        #1;
        check("idle_valid", 64'(a_ovalid), 64'd0);

        // All requesting, always ready: strict rotation 0..3 twice.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NA; i++) push_a(i, 1);
        a_valid  = 4'b1111;
        a_oready = 1'b1;
        #1;
`ifdef ISO_HS_ARB_OUT_REG_EN
        check("first_valid_latency", 64'(a_ovalid), 64'd0);
        repeat (16) tick();
`else
        check("first_valid_latency", 64'(a_ovalid), 64'd1);
        repeat (8) tick();
`endif
        a_valid = '0;

`ifndef ISO_HS_ARB_OUT_REG_EN
        // Stall on idx 0 for five cycles, then serve 0 and 2.
        set_data(2);
        push_a(0, 2);
        a_valid  = 4'b0101;
        a_oready = 1'b0;
        repeat (5) tick();
        a_oready = 1'b1;
        push_a(2, 2);
        repeat (2) tick();
        a_valid = '0;

        // Stall on idx 1; requester 0 arrives mid-stall but must wait.
        set_data(3);
        push_a(1, 3);
        a_valid  = 4'b0010;
        a_oready = 1'b0;
        repeat (2) tick();
        a_valid = 4'b0011;
        repeat (2) tick();
        a_oready = 1'b1;
        push_a(0, 3);
        repeat (2) tick();
        a_valid = '0;

        // Reset during a stall on idx 3 drops the lock.
        set_data(4);
        push_a(3, 4);
        a_valid  = 4'b1000;
        a_oready = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(a_ovalid), 64'd0);
        check("midrst_ready", 64'(a_ready), 64'd0);
        check("midrst_idx", 64'(a_oidx), 64'd0);
        qa.delete();
        a_valid  = 4'b0010;
        a_oready = 1'b1;
        push_a(1, 4);
        tick();
        rst_n = 1'b1;
        #1;
        check("postrst_valid", 64'(a_ovalid), 64'd1);
        check("postrst_idx", 64'(a_oidx), 64'd1);
        tick();
        a_valid  = '0;
        a_oready = 1'b0;
`endif

        // Three requesters: pointer wraps from 2 back to 0.
        set_data(5);
        push_b(0, 5);
        push_b(1, 5);
        push_b(2, 5);
        push_b(0, 5);
        b_valid  = 3'b111;
        b_oready = 1'b1;
`ifdef ISO_HS_ARB_OUT_REG_EN
        repeat (8) tick();
`else
        repeat (4) tick();
`endif
        b_valid  = '0;
        b_oready = 1'b0;

        repeat (3) tick();
        check("a_queue_drained", 64'(qa.size()), 64'd0);
        check("b_queue_drained", 64'(qb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
